// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: glyph table,
// blank pattern and the digit-index width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high glyphs, bit order g..a, entry n is hex digit n
  localparam logic [15:0][6:0] GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-register side and pin side signals of the scan controller.
interface seg7_scan_ctrl_if #(
  parameter int unsigned NDIG = 4
);
  logic [4*NDIG-1:0] din;
  logic [NDIG-1:0]   dp_in;
  logic [NDIG-1:0]   blank_in;
  logic              load;
  logic [6:0]        seg;
  logic              dp;
  logic [NDIG-1:0]   an;
  logic              frame;

  modport master (
    output din, dp_in, blank_in, load,
    input  seg, dp, an, frame
  );

  modport slave (
    input  din, dp_in, blank_in, load,
    output seg, dp, an, frame
  );
endinterface

// File: rtl/seg7_hexdec.sv
// Nibble to active-high seven-segment glyph, forced dark when blank_i is set.
module seg7_hexdec
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = GLYPH[nib_i];
    if (blank_i) seg_o = SEG_BLANK;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: shadow register, per-slot
// latch, dead-cycle anode gating and registered, polarity-adjusted outputs.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG        = 4,
  parameter int unsigned PRESC       = 1024,
  parameter int unsigned ACTIVE_LOW  = 1,
  parameter int unsigned LZ_SUPPRESS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_scan_ctrl_if.slave      bus
);

  localparam int unsigned PW  = $clog2(PRESC);
  localparam int unsigned IW  = idx_width(NDIG);
  localparam logic        INV = (ACTIVE_LOW != 0);

  logic [PW-1:0]        pcnt_q, pcnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NDIG-1:0][3:0] shd_din_q;
  logic [NDIG-1:0]      shd_dp_q, shd_blank_q;
  logic [3:0]           slot_nib_q;
  logic                 slot_dp_q, slot_dark_q;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [NDIG-1:0]      an_q, an_d;
  logic                 frame_q, frame_d;

  logic                 pcnt_wrap, idx_wrap, dead;
  logic [NDIG-1:0]      lz_mask;
  logic                 lead_zero;
  logic [6:0]           glyph;

  assign pcnt_wrap = (pcnt_q == PW'(PRESC - 1));
  assign idx_wrap  = (idx_q == IW'(NDIG - 1));
  assign dead      = (pcnt_q == '0);

  // Slot timing; frame is set on the edge entering the last cycle of the frame
  always_comb begin
    pcnt_d = pcnt_wrap ? '0 : pcnt_q + PW'(1);
    idx_d  = idx_q;
    if (pcnt_wrap) idx_d = idx_wrap ? '0 : idx_q + IW'(1);
    frame_d = (pcnt_d == PW'(PRESC - 1)) && (idx_d == IW'(NDIG - 1));
  end

  // Digit k is a leading zero when it and every digit above it are zero
  always_comb begin
    lz_mask   = '0;
    lead_zero = 1'b1;
    for (int k = int'(NDIG) - 1; k >= 1; k--) begin
      lead_zero            = lead_zero & (shd_din_q[IW'(k)] == 4'h0);
      lz_mask[IW'(k)]      = lead_zero & (LZ_SUPPRESS != 0);
    end
  end

  seg7_hexdec u_dec (
    .nib_i   (slot_nib_q),
    .blank_i (slot_dark_q),
    .seg_o   (glyph)
  );

  always_comb begin
    an_d  = dead ? '0 : (NDIG'(1) << idx_q);
    seg_d = dead ? SEG_BLANK : glyph;
    dp_d  = ~dead & slot_dp_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q      <= '0;
      idx_q       <= '0;
      shd_din_q   <= '0;
      shd_dp_q    <= '0;
      shd_blank_q <= '0;
      slot_nib_q  <= '0;
      slot_dp_q   <= 1'b0;
      slot_dark_q <= 1'b0;
      seg_q       <= SEG_BLANK ^ {7{INV}};
      dp_q        <= INV;
      an_q        <= {NDIG{INV}};
      frame_q     <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      if (bus.load) begin
        shd_din_q   <= bus.din;
        shd_dp_q    <= bus.dp_in;
        shd_blank_q <= bus.blank_in;
      end
      // Latch the slot contents once, so a mid-slot load never tears the digit
      if (dead) begin
        slot_nib_q  <= shd_din_q[idx_q];
        slot_dp_q   <= shd_dp_q[idx_q] & ~shd_blank_q[idx_q];
        slot_dark_q <= shd_blank_q[idx_q] | lz_mask[idx_q];
      end
      seg_q <= seg_d ^ {7{INV}};
      dp_q  <= dp_d ^ INV;
      an_q  <= an_d ^ {NDIG{INV}};
    end
  end

  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.an    = an_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench: three controller variants (active-high, active-low,
// leading-zero suppression) driven with identical display data.
module tb_seg7_scan_ctrl;

  localparam int unsigned NDIG  = 4;
  localparam int unsigned PRESC = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.NDIG(NDIG)) bus0 ();
  seg7_scan_ctrl_if #(.NDIG(NDIG)) bus1 ();
  seg7_scan_ctrl_if #(.NDIG(NDIG)) bus2 ();

  seg7_scan_ctrl #(.NDIG(NDIG), .PRESC(PRESC), .ACTIVE_LOW(0), .LZ_SUPPRESS(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  seg7_scan_ctrl #(.NDIG(NDIG), .PRESC(PRESC), .ACTIVE_LOW(1), .LZ_SUPPRESS(0))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  seg7_scan_ctrl #(.NDIG(NDIG), .PRESC(PRESC), .ACTIVE_LOW(0), .LZ_SUPPRESS(1))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic [3:0] dpv,
                       input logic [3:0] bl, input logic ld);
    bus0.din = d;   bus1.din = d;   bus2.din = d;
    bus0.dp_in = dpv; bus1.dp_in = dpv; bus2.dp_in = dpv;
    bus0.blank_in = bl; bus1.blank_in = bl; bus2.blank_in = bl;
    bus0.load = ld; bus1.load = ld; bus2.load = ld;
  endtask

  task automatic set_load(input logic ld);
    bus0.load = ld; bus1.load = ld; bus2.load = ld;
  endtask

  task automatic chk_inactive(input string tag);
    chk({tag, " an0"},    32'(bus0.an),    32'h0);
    chk({tag, " seg0"},   32'(bus0.seg),   32'h00);
    chk({tag, " dp0"},    32'(bus0.dp),    32'h0);
    chk({tag, " frame0"}, 32'(bus0.frame), 32'h0);
    chk({tag, " an1"},    32'(bus1.an),    32'hF);
    chk({tag, " seg1"},   32'(bus1.seg),   32'h7F);
    chk({tag, " dp1"},    32'(bus1.dp),    32'h1);
  endtask

  // Runs one 16-cycle frame starting at the (idx 0, pcnt 0) cycle.
  // exp0: glyphs for the plain variants, exp2: glyphs with LZ suppression,
  // both ordered {d3,d2,d1,d0}. load_k selects the edge that loads new data.
  task automatic scan_frame(input string tag,
                            input logic [3:0][6:0] exp0,
                            input logic [3:0][6:0] exp2,
                            input logic [3:0] exp_dp,
                            input int load_k,
                            input logic [15:0] ld_din,
                            input logic [3:0] ld_dp,
                            input logic [3:0] ld_blank);
    for (int k = 1; k <= 16; k++) begin
      int         s;
      int         d;
      logic       active;
      logic [3:0] e_an;
      logic [3:0] e_an_n;
      logic [6:0] e_seg_n;
      logic       e_dp_n;
      if (k == load_k) drive(ld_din, ld_dp, ld_blank, 1'b1);
      else             set_load(1'b0);
      @(negedge clk);
      s       = k - 1;
      d       = s / 4;
      active  = (s % 4) != 0;
      e_an    = active ? 4'(1 << d) : 4'h0;
      e_an_n  = ~e_an;
      e_seg_n = ~exp0[d];
      e_dp_n  = ~exp_dp[d];
      chk($sformatf("%s k%0d frame", tag, k), 32'(bus0.frame), 32'(k == 15));
      chk($sformatf("%s k%0d an0", tag, k), 32'(bus0.an), 32'(e_an));
      chk($sformatf("%s k%0d an1", tag, k), 32'(bus1.an), 32'(e_an_n));
      if (active) begin
        chk($sformatf("%s k%0d seg0", tag, k), 32'(bus0.seg), 32'(exp0[d]));
        chk($sformatf("%s k%0d seg1", tag, k), 32'(bus1.seg), 32'(e_seg_n));
        chk($sformatf("%s k%0d seg2", tag, k), 32'(bus2.seg), 32'(exp2[d]));
        chk($sformatf("%s k%0d dp0", tag, k),  32'(bus0.dp),  32'(exp_dp[d]));
        chk($sformatf("%s k%0d dp1", tag, k),  32'(bus1.dp),  32'(e_dp_n));
      end
    end
    set_load(1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(16'h0000, 4'h0, 4'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk_inactive("reset");
    chk("reset seg2", 32'(bus2.seg), 32'h00);

    // Load lands on the digit-0 latch edge: digit 0 still shows the old shadow
    rst = 1'b0;
    scan_frame("A", {7'h7F, 7'h3F, 7'h5B, 7'h3F}, {7'h7F, 7'h3F, 7'h5B, 7'h3F},
               4'b0000, 1, 16'h8025, 4'h0, 4'h0);
    scan_frame("B", {7'h7F, 7'h3F, 7'h5B, 7'h6D}, {7'h7F, 7'h3F, 7'h5B, 7'h6D},
               4'b0000, 0, 16'h0000, 4'h0, 4'h0);
    // dp on digits 1,2 with digit 2 blanked; LZ dark on digit 3
    scan_frame("C", {7'h3F, 7'h00, 7'h66, 7'h6D}, {7'h00, 7'h00, 7'h66, 7'h6D},
               4'b0010, 1, 16'h0040, 4'b0110, 4'b0100);
    scan_frame("D", {7'h3F, 7'h00, 7'h66, 7'h3F}, {7'h00, 7'h00, 7'h66, 7'h3F},
               4'b0010, 0, 16'h0000, 4'h0, 4'h0);
    scan_frame("E", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, {7'h00, 7'h00, 7'h00, 7'h3F},
               4'b0000, 1, 16'h0000, 4'h0, 4'h0);
    // Load mid-slot (digit 1, pcnt 2): digit 1 keeps its old glyph
    scan_frame("F", {7'h71, 7'h71, 7'h3F, 7'h3F}, {7'h71, 7'h71, 7'h00, 7'h3F},
               4'b0000, 7, 16'hFFFF, 4'h0, 4'h0);

    // Abort at idx 2, pcnt 3
    repeat (11) @(negedge clk);
    chk("premature an0", 32'(bus0.an), 32'h4);
    rst = 1'b1;
    #1;
    chk_inactive("async rst");
    @(negedge clk);
    rst = 1'b0;
    scan_frame("R", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, {7'h00, 7'h00, 7'h00, 7'h3F},
               4'b0000, 0, 16'h0000, 4'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
